// File: rtl/cpu_out_trace.sv
// cpu_out_trace
//   Watches the CPU output bus and records every value change, together with
//   a cycle timestamp, into a circular trace buffer. It also flags program
//   completion once the bus has stayed quiet for HALT_CYCLES enabled cycles.
//   Entries are drained oldest-first over a valid/ready read port.
//
// Ports
//   boardCLK  : clock, all state updates on the rising edge
//   reset     : synchronous, active-high reset
//   enable    : timestamp, halt counter, FSM and capture advance only while 1
//   mode_wrap : 0 = drop new entries when full, 1 = overwrite oldest when full
//   cpu_out   : monitored CPU output bus
//   rd_ready  : consumer takes the head entry this cycle
//   rd_valid  : buffer holds at least one entry
//   rd_data   : value of the oldest entry
//   rd_ts     : timestamp of the oldest entry
//   count     : number of entries held
//   overflow  : sticky, some entry was dropped or overwritten
//   halted    : sticky, program completion detected
module cpu_out_trace #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int TS_W        = 16,
  parameter int HALT_CYCLES = 330
) (
  input  logic                     boardCLK,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mode_wrap,
  input  logic [DATA_W-1:0]        cpu_out,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int HC_W  = $clog2(HALT_CYCLES + 1);

  localparam logic [TS_W-1:0]  TS_MAX   = '1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [HC_W-1:0]  HALT_LIM = HC_W'(HALT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [HC_W-1:0]   halt_cnt_q, halt_cnt_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              halted_q, halted_d;

  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [TS_W-1:0]   mem_ts_q   [DEPTH];

  logic capture;
  logic pop;
  logic full;
  logic mem_we;

  // Capture decision, timestamp and halt detection. A capture in RUN takes
  // priority over the halt threshold, so a change arriving on the very cycle
  // the counter would expire keeps the program running.
  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    halt_cnt_d = halt_cnt_q;
    last_d     = last_q;
    halted_d   = halted_q;
    capture    = 1'b0;
    if (enable) begin
      if (ts_q != TS_MAX) begin
        ts_d = ts_q + TS_W'(1);
      end
      case (state_q)
        IDLE: begin
          capture    = 1'b1;
          halt_cnt_d = '0;
          state_d    = RUN;
        end
        RUN: begin
          if (cpu_out != last_q) begin
            capture    = 1'b1;
            halt_cnt_d = '0;
          end else if (halt_cnt_q + HC_W'(1) == HALT_LIM) begin
            halt_cnt_d = HALT_LIM;
            halted_d   = 1'b1;
            state_d    = HALTED;
          end else begin
            halt_cnt_d = halt_cnt_q + HC_W'(1);
          end
        end
        default: begin
        end
      endcase
      if (capture) begin
        last_d = cpu_out;
      end
    end
  end

  // Circular buffer bookkeeping. A simultaneous pop frees the head slot, so
  // a push is always accepted then, even when the buffer is full.
  always_comb begin
    rd_valid   = (count_q != '0);
    full       = (count_q == FULL_CNT);
    pop        = rd_valid && rd_ready;
    mem_we     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (capture) begin
      if (pop || !full) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else if (mode_wrap) begin
        mem_we     = 1'b1;
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        overflow_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (capture && !pop && !full) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !capture) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control state and status flags.
  always_ff @(posedge boardCLK) begin
    if (reset) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      halt_cnt_q <= '0;
      last_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      halt_cnt_q <= halt_cnt_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      halted_q   <= halted_d;
    end
  end

  // Trace storage has no reset; only slots between the pointers are meaningful.
  always_ff @(posedge boardCLK) begin
    if (mem_we) begin
      mem_data_q[wr_ptr_q] <= cpu_out;
      mem_ts_q[wr_ptr_q]   <= ts_q;
    end
  end

  // Head entry is shown combinationally; forced to zero while empty so the
  // read port is clean straight out of reset.
  always_comb begin
    rd_data = '0;
    rd_ts   = '0;
    if (rd_valid) begin
      rd_data = mem_data_q[rd_ptr_q];
      rd_ts   = mem_ts_q[rd_ptr_q];
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign halted   = halted_q;

endmodule
